baud_select_arbiter: RTL and testbench

Configuration controller in front of `baud_controller`. It shares the single `baud_select` setting between two requesters (transmit side and receive side) with a req/ack handshake and round-robin arbitration. A rate change is applied only once both channels are idle; the controller then restarts the baud generator and waits a fixed number of `sample_ENABLE` ticks before acknowledging, so neither channel ever samples across a rate change.

---
 rtl/baud_select_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_baud_select_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/baud_select_arbiter.sv
// Shares one baud_select code between TX and RX requesters; a new rate is applied only when both channels are idle.
// Optional DRAIN timeout enabled by defining BAUD_ARB_TIMEOUT_EN (default build: err0/err1 tied low).
`timescale 1ns/1ps
module baud_select_arbiter #(
  parameter int unsigned SETTLE_TICKS   = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [2:0]  RESET_SEL      = 3'b000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [2:0] sel0,
  input  logic       req1,
  input  logic [2:0] sel1,
  input  logic       tx_idle,
  input  logic       rx_idle,
  input  logic       sample_ENABLE,
  output logic [2:0] baud_select,
  output logic       baud_reset,
  output logic       hold,
  output logic       ack0,
  output logic       ack1,
  output logic       err0,
  output logic       err1,
  output logic       busy
);

  // state  | meaning
  // IDLE   | waiting for a request; round-robin grant
  // DRAIN  | hold channels, wait for tx_idle && rx_idle
  // APPLY  | new code loaded, baud generator in reset (one cycle)
  // SETTLE | count SETTLE_TICKS sample_ENABLE pulses
  // DONE   | ack the owner
  // ERR    | DRAIN timed out, err to the owner
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    APPLY  = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_TICKS - 1);

  if (SETTLE_TICKS < 1 || SETTLE_TICKS > 255 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("baud_select_arbiter: SETTLE_TICKS must be 1..255 and TIMEOUT_CYCLES >= 1");
  end

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_grant, last_grant_nxt;
  logic [2:0] sel_lat, sel_lat_nxt;
  logic [7:0] settle_cnt, settle_cnt_nxt;
  logic [2:0] baud_select_nxt;
  logic       baud_reset_nxt;
  logic       hold_nxt;
  logic       ack0_nxt, ack1_nxt;
  logic       busy_nxt;
  logic       grant1;
  logic [2:0] grant_sel;
  logic       tmo_expired;

`ifdef BAUD_ARB_TIMEOUT_EN
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Reloaded whenever we are outside DRAIN, so it reads zero in the last allowed DRAIN cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= TMO_LOAD;
    end else if (state != DRAIN) begin
      tmo_cnt <= TMO_LOAD;
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  assign tmo_expired = (tmo_cnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      err0 <= 1'b0;
      err1 <= 1'b0;
    end else begin
      err0 <= (state_nxt == ERR) & ~owner;
      err1 <= (state_nxt == ERR) & owner;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign err0        = 1'b0;
  assign err1        = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    last_grant_nxt  = last_grant;
    sel_lat_nxt     = sel_lat;
    settle_cnt_nxt  = settle_cnt;
    baud_select_nxt = baud_select;
    baud_reset_nxt  = 1'b0;
    hold_nxt        = 1'b0;
    // last_grant=1 means requester 1 was served last, so requester 0 wins a tie
    grant1          = req1 & (~req0 | ~last_grant);
    grant_sel       = grant1 ? sel1 : sel0;

    case (state)
      IDLE: begin
        if (req0 | req1) begin
          owner_nxt      = grant1;
          last_grant_nxt = grant1;
          sel_lat_nxt    = grant_sel;
          if (grant_sel == baud_select) begin
            state_nxt = DONE;
          end else begin
            state_nxt = DRAIN;
            hold_nxt  = 1'b1;
          end
        end
      end
      DRAIN: begin
        hold_nxt = 1'b1;
        if (tx_idle && rx_idle) begin
          state_nxt       = APPLY;
          baud_select_nxt = sel_lat;
          baud_reset_nxt  = 1'b1;
        end else if (tmo_expired) begin
          state_nxt = ERR;
        end
      end
      APPLY: begin
        state_nxt      = SETTLE;
        settle_cnt_nxt = '0;
        hold_nxt       = 1'b1;
      end
      SETTLE: begin
        hold_nxt = 1'b1;
        if (sample_ENABLE) begin
          if (settle_cnt == SETTLE_LAST) begin
            state_nxt = DONE;
          end else begin
            settle_cnt_nxt = settle_cnt + 8'd1;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    ack0_nxt = (state_nxt == DONE) & ~owner_nxt;
    ack1_nxt = (state_nxt == DONE) & owner_nxt;
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      sel_lat     <= RESET_SEL;
      settle_cnt  <= '0;
      baud_select <= RESET_SEL;
      baud_reset  <= 1'b1;
      hold        <= 1'b0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      last_grant  <= last_grant_nxt;
      sel_lat     <= sel_lat_nxt;
      settle_cnt  <= settle_cnt_nxt;
      baud_select <= baud_select_nxt;
      baud_reset  <= baud_reset_nxt;
      hold        <= hold_nxt;
      ack0        <= ack0_nxt;
      ack1        <= ack1_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_baud_select_arbiter.sv
// Bench for baud_select_arbiter: per-transaction expectations derived from event timing of the drive patterns.
`timescale 1ns/1ps
module tb_baud_select_arbiter;

  localparam int ST = 4;
`ifdef BAUD_ARB_TIMEOUT_EN
  localparam int TO = 50;
`else
  localparam int TO = 1_000_000;
`endif
  localparam logic [2:0] RSEL = 3'b000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] sel0 = 3'b000, sel1 = 3'b000;
  logic       tx_idle = 1'b1, rx_idle = 1'b1;
  logic       sample_ENABLE = 1'b0;
  logic [2:0] baud_select;
  logic       baud_reset, hold, ack0, ack1, err0, err1, busy;

  int vectors = 0;
  int miscompares = 0;

  logic [2:0] m_sel;
  bit         m_last;
  bit         idle_pat[256];
  bit         tick_pat[256];

  baud_select_arbiter #(
    .SETTLE_TICKS  (ST),
    .TIMEOUT_CYCLES(TO),
    .RESET_SEL     (RSEL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req0         (req0),
    .sel0         (sel0),
    .req1         (req1),
    .sel1         (sel1),
    .tx_idle      (tx_idle),
    .rx_idle      (rx_idle),
    .sample_ENABLE(sample_ENABLE),
    .baud_select  (baud_select),
    .baud_reset   (baud_reset),
    .hold         (hold),
    .ack0         (ack0),
    .ack1         (ack1),
    .err0         (err0),
    .err1         (err1),
    .busy         (busy)
  );

  always #10 clk = ~clk;

  function automatic logic [9:0] obs();
    return {baud_select, baud_reset, hold, ack0, ack1, err0, err1, busy};
  endfunction

  task automatic drive_pat(input int i);
    if (idle_pat[i]) begin
      tx_idle = 1'b1;
      rx_idle = 1'b1;
    end else begin
      tx_idle = 1'($urandom_range(0, 1));
      rx_idle = tx_idle ? 1'b0 : 1'($urandom_range(0, 1));
    end
    sample_ENABLE = tick_pat[i];
  endtask

  // Cycle 0 is the IDLE cycle whose closing edge grants; expectations are event times relative to it.
  task automatic serve(input string name, input bit r0, input bit r1,
                       input logic [2:0] s0, input logic [2:0] s1,
                       input int idle_wait, input bit apply_tick);
    bit         own, fast, tmo;
    logic [2:0] nsel;
    int         d, k, e, cnt;
    logic [9:0] want, got;
    own  = (r0 && r1) ? !m_last : r1;
    nsel = own ? s1 : s0;
    fast = (nsel == m_sel);
    for (int i = 0; i < 256; i++) begin
      idle_pat[i] = (i >= idle_wait);
      tick_pat[i] = (i > 150) || ($urandom_range(0, 2) == 0);
    end
    d = 1;
    while (d < 200 && !idle_pat[d]) d++;
    tmo = !fast && (d > TO);
    k = 0;
    e = 1;
    if (!fast && tmo) begin
      e = TO + 1;
    end else if (!fast) begin
      if (apply_tick) tick_pat[d + 1] = 1'b1;
      cnt = 0;
      for (int i = d + 2; i < 256 && k == 0; i++) begin
        if (tick_pat[i]) cnt++;
        if (cnt == ST) k = i;
      end
      e = k + 1;
    end

    req0 = r0;
    req1 = r1;
    sel0 = s0;
    sel1 = s1;
    drive_pat(0);
    for (int j = 1; j <= e; j++) begin
      @(posedge clk);
      #1;
      want[9:7] = (!fast && !tmo && j >= d + 1) ? nsel : m_sel;
      want[6]   = !fast && !tmo && (j == d + 1);
      want[5]   = !fast;
      want[4]   = (j == e) && !tmo && !own;
      want[3]   = (j == e) && !tmo && own;
      want[2]   = (j == e) && tmo && !own;
      want[1]   = (j == e) && tmo && own;
      want[0]   = 1'b1;
      got = obs();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s cycle %0d: got %b want %b (sel,baud_reset,hold,ack0,ack1,err0,err1,busy)",
                 name, j, got, want);
      end
      if (j == e) begin
        if (own) req1 = 1'b0;
        else req0 = 1'b0;
        drive_pat(255);
      end else begin
        drive_pat(j);
      end
    end
    @(posedge clk);
    #1;
    if (!fast && !tmo) m_sel = nsel;
    m_last = own;
    want = {m_sel, 7'b0000000};
    got  = obs();
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s back_to_idle: got %b want %b", name, got, want);
    end
  endtask

  task automatic test_reset;
    logic [9:0] want;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    want = {RSEL, 7'b1000000};
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("FAIL reset_values: got %b want %b", obs(), want);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("FAIL reset_release_same_cycle: got %b want %b", obs(), want);
    end
    @(posedge clk);
    #1;
    want = {RSEL, 7'b0000000};
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("FAIL reset_release_next: got %b want %b", obs(), want);
    end
    m_sel  = RSEL;
    m_last = 1'b1;
  endtask

  task automatic test_arbitration;
    serve("arb_both_first", 1'b1, 1'b1, 3'b001, 3'b101, 0, 0);
    serve("arb_both_second", 1'b0, 1'b1, 3'b001, 3'b101, 0, 0);
    serve("arb_single0", 1'b1, 1'b0, 3'b010, 3'b000, 1, 0);
    serve("arb_rr_first", 1'b1, 1'b1, 3'b110, 3'b011, 2, 1);
    serve("arb_rr_second", 1'b1, 1'b0, 3'b110, 3'b011, 0, 0);
  endtask

  task automatic test_single;
    serve("single_011", 1'b1, 1'b0, 3'b011, 3'b000, 0, 1);
  endtask

  task automatic test_fast_path;
    serve("fast_req1", 1'b0, 1'b1, 3'b000, m_sel, 0, 0);
    serve("fast_req0", 1'b1, 1'b0, m_sel, 3'b000, 0, 0);
  endtask

  task automatic test_drain_stall;
    serve("drain_stall", 1'b1, 1'b0, m_sel ^ 3'b101, 3'b000, 100, 0);
  endtask

  task automatic test_reset_in_settle;
    logic [9:0] want;
    req0 = 1'b1;
    sel0 = m_sel ^ 3'b110;
    req1 = 1'b0;
    tx_idle = 1'b1;
    rx_idle = 1'b1;
    sample_ENABLE = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    want = {sel0, 7'b0100001};
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("FAIL settle_entry: got %b want %b", obs(), want);
    end
    reset = 1'b0;
    sample_ENABLE = 1'b1;
    @(posedge clk);
    #1;
    want = {RSEL, 7'b1000000};
    vectors++;
    if (obs() !== want) begin
      miscompares++;
      $display("FAIL reset_in_settle: got %b want %b", obs(), want);
    end
    reset = 1'b1;
    req0 = 1'b0;
    m_sel = RSEL;
    m_last = 1'b1;
    want = {RSEL, 7'b0000000};
    for (int n = 0; n < 20; n++) begin
      sample_ENABLE = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      vectors++;
      if (obs() !== want) begin
        miscompares++;
        $display("FAIL after_abort cycle %0d: got %b want %b", n, obs(), want);
      end
    end
  endtask

  task automatic test_random;
    bit         r0, r1;
    logic [2:0] s0, s1;
    for (int n = 0; n < 24; n++) begin
      r0 = req0 || ($urandom_range(0, 1) == 1);
      r1 = req1 || ($urandom_range(0, 1) == 1);
      if (!r0 && !r1) r0 = 1'b1;
      s0 = req0 ? sel0 : 3'($urandom_range(0, 7));
      s1 = req1 ? sel1 : 3'($urandom_range(0, 7));
      serve("random", r0, r1, s0, s1, $urandom_range(0, 40), 1'($urandom_range(0, 1)));
    end
    if (req0 || req1) serve("random_tail", req0, req1, sel0, sel1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single();
    test_fast_path();
    test_drain_stall();
    test_reset_in_settle();
    test_random();
    test_fast_path();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not reach its summary in time");
    $fatal(1, "watchdog expired");
  end

endmodule
